// File: rtl/led_seq_gen_pkg.sv
// Shared types and constants for the LED sequence generator.
package led_seq_pkg;

    localparam int unsigned CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    // Bounce-mode travel direction; also mirrors dir while in wrap mode.
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } state_t;

    localparam logic WRAP   = 1'b0;
    localparam logic BOUNCE = 1'b1;

    localparam code_t CODE_MIN = CODE_W'(0);
    localparam code_t CODE_MAX = CODE_W'(7);

endpackage

// File: rtl/led_seq_gen_if.sv
// Control/status bundle between a controller and led_seq_gen.
//   en, mode, dir, step_req : controls into the generator
//   out1..out3              : registered 3-bit code, MSB first, to the decoder
//   step_tick               : one-cycle pulse when a new code appears
interface led_seq_gen_if;

    logic en;
    logic mode;
    logic dir;
    logic step_req;
    logic out1;
    logic out2;
    logic out3;
    logic step_tick;

    modport master (
        output en, mode, dir, step_req,
        input  out1, out2, out3, step_tick
    );

    modport slave (
        input  en, mode, dir, step_req,
        output out1, out2, out3, step_tick
    );

endinterface

// File: rtl/led_seq_gen_tick_div.sv
// Free-running step divider: one timer event every CNT_MAX+1 enabled clocks.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   en               : 1 = count, 0 = hold
//   tick             : high during the cycle the counter sits at CNT_MAX
module tick_div #(
    parameter int unsigned CNT_MAX = 24_999_999,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic             at_max_c;

    assign at_max_c = (cnt_q == CNT_W'(CNT_MAX));

    // Combinational so the consumer advances on the same edge the counter wraps.
    assign tick = en && at_max_c;

    // Counter: wraps to 0 after CNT_MAX, frozen while en is low.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_max_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_gen.sv
// Timed 3-bit code source for a 3-to-8 one-hot decoder (running light).
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : en/mode/dir/step_req in; out1..out3/step_tick out
// Wrap mode counts up or down modulo 8; bounce mode ping-pongs 0..7..0
// without repeating the endpoints. All outputs come straight from flops.
module led_seq_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned CNT_MAX = 24_999_999,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    led_seq_gen_if.slave  bus
);

    logic   tick_c;
    logic   adv_c;
    state_t state_q, state_d;
    code_t  code_q, code_d;
    logic   step_tick_q, step_tick_d;

    tick_div #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_tick_div (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (bus.en),
        .tick    (tick_c)
    );

    // A coincident timer event and manual request merge into one advance.
    assign adv_c = tick_c || bus.step_req;

    // State, code and pulse registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= UP;
            code_q      <= CODE_MIN;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            step_tick_q <= step_tick_d;
        end
    end

    // Next code / direction.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        step_tick_d = adv_c;

        if (bus.mode == WRAP) begin
            // Track dir continuously so a later bounce starts the same way.
            state_d = bus.dir ? DOWN : UP;
            if (adv_c) begin
                code_d = bus.dir ? code_q - CODE_W'(1) : code_q + CODE_W'(1);
            end
        end else if (adv_c) begin
            case (state_q)
                UP: begin
                    if (code_q == CODE_MAX) begin
                        code_d  = CODE_MAX - CODE_W'(1);
                        state_d = DOWN;
                    end else begin
                        code_d = code_q + CODE_W'(1);
                    end
                end
                DOWN: begin
                    if (code_q == CODE_MIN) begin
                        code_d  = CODE_MIN + CODE_W'(1);
                        state_d = UP;
                    end else begin
                        code_d = code_q - CODE_W'(1);
                    end
                end
                default: begin
                    state_d = UP;
                end
            endcase
        end
    end

    assign bus.out1      = code_q[2];
    assign bus.out2      = code_q[1];
    assign bus.out3      = code_q[0];
    assign bus.step_tick = step_tick_q;

endmodule

// File: doc/led_seq_gen.md
Name: led_seq_gen

Overview:
- Upstream code generator for the 3-to-8 one-hot decoder stage; drives its three select inputs (MSB first) with a timed 3-bit sequence.
- Produces a running-light pattern on the 8 decoded outputs in wrap or bounce mode.
- Supports a manual single-step request.
- Sits between the board clock/reset and the decoder; the decoder stays purely combinational.

Parameters:
- CNT_MAX, 24_999_999, divider terminal count; one step every CNT_MAX+1 clocks (0.5 s at 50 MHz); legal range >= 1.
- CNT_W, $clog2(CNT_MAX+1), divider counter width (derived, not overridden).

Ports:
- sys_clk  input  1  system clock, all logic on its rising edge
- sys_rst  input  1  synchronous, active-high reset
- en  input  1  1 = divider runs; 0 = divider holds its value
- mode  input  1  0 = wrap, 1 = bounce
- dir  input  1  wrap direction: 0 = up, 1 = down; ignored in bounce mode
- step_req  input  1  single-cycle manual advance pulse; honoured regardless of en
- out1  output  1  code bit 2 (MSB), drives decoder in1
- out2  output  1  code bit 1, drives decoder in2
- out3  output  1  code bit 0 (LSB), drives decoder in3
- step_tick  output  1  registered one-cycle pulse, high in the cycle the new code first appears

Behaviour:
- Reset (sys_rst=1 at a clock edge): cnt=0, code=3'b000 (decoder output 8'b0000_0001), state=UP, step_tick=0. Reset overrides every other input, including mid-count and mid-bounce.
- Divider:
  - If en=1: cnt increments each clock; when cnt==CNT_MAX, that cycle is a timer event and cnt returns to 0.
  - If en=0: cnt holds; no timer events.
- Advance event = timer event OR step_req. Both in the same cycle give exactly one advance. step_req does not touch cnt.
- Latency: code and step_tick update on the clock edge that samples the advance event. The new code is visible on out1..out3 in the following cycle, together with step_tick=1.
- Wrap mode (mode=0):
  - Up: 0,1,...,7,0,... (7 -> 0 wrap).
  - Down: 7,6,...,0,7,... (0 -> 7 wrap).
  - state register loads UP/DOWN from dir every cycle, so bounce mode starts in the last wrap direction.
  - A dir change takes effect at the next advance.
- Bounce mode (mode=1), two-state FSM:
  - UP: code==7 -> code=6, state=DOWN; otherwise code+1.
  - DOWN: code==0 -> code=1, state=UP; otherwise code-1.
  - Resulting sequence from 0/UP: 0..7,6..1,0,1... Endpoints are never repeated.
- Mode switch between advances: code is kept and the next advance uses the new mode's rule. No glitch, no extra step.
- Arithmetic is 3-bit unsigned with explicit wrap; no intermediate values wider than 3 bits reach the outputs.
- Outputs come directly from flops (no combinational path from inputs), so the decoder sees only clean registered codes.

Decomposition:
- Package led_seq_pkg:
  - CODE_W=3
  - state enum {UP=1'b0, DOWN=1'b1}
  - mode constants WRAP=1'b0, BOUNCE=1'b1
- Sub-module tick_div (parameters CNT_MAX/CNT_W; ports sys_clk, sys_rst, en, tick): holds the divider and emits the one-cycle timer event.
- The top level holds the code register, FSM and step_tick flop.

Test Plan (CNT_MAX=3 unless noted):
- Reset, en=1, mode=0, dir=0, run 40 clocks -> code 0 after reset; steps to 1,2,...,7,0 every 4 clocks; step_tick high exactly one cycle per step; decoder output walks 0x01->0x02->...->0x80->0x01.
- mode=0, dir=1 from code 2 -> 1,0,7,6; flip dir to 0 mid-interval -> next step goes up from the current code.
- mode=1 from code 5/UP -> 6,7,6,5,...,1,0,1; no repeated 7 or 0; state switches at the endpoints only.
- en=0 with step_req pulses at arbitrary cycles -> exactly one advance per pulse, cnt frozen; step_req coincident with a timer event (en=1) -> single advance, not two.
- sys_rst asserted mid-bounce at code 4/DOWN -> next cycle code=0, state=UP, cnt=0, step_tick=0; first post-reset step after 4 clocks -> code 1.
- CNT_MAX=1 (minimum) -> a step every 2 clocks; wrap 7->0 correct; no missed or double ticks over 64 clocks.
